// File: rtl/drac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drac_pkg
// Description : Shared types for the fetch sequencer: program-counter type
//               and the fence.i sequencer state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package drac_pkg;

  localparam int ADDR_PC_W = 64;

  typedef logic [ADDR_PC_W-1:0] addrPC_t;

  // Encoding is fixed so the top level can mirror it as plain constants.
  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_DRAIN  = 2'd1,
    FS_INVAL  = 2'd2,
    FS_RESUME = 2'd3
  } fetch_seq_state_t;

endpackage : drac_pkg
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : fetch_watchdog
// Description : Tracks whether an icache request is outstanding and times it.
//               When the request has waited TIMEOUT_CYCLES cycles without a
//               response, a single-cycle retry pulse is produced.
// Ports       : clk_i, rstn_i          clock / async active-low reset
//               fetch_req_valid_i      request issued this cycle
//               icache_resp_valid_i    response arrived
//               flush_req_i            kill the outstanding request
//               outstanding_o          registered outstanding flag
//               fire_evt_o             timeout fires at the next edge
//               retry_o                registered retry pulse
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_watchdog
  import drac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic fetch_req_valid_i,
  input  logic icache_resp_valid_i,
  input  logic flush_req_i,
  output logic outstanding_o,
  output logic fire_evt_o,
  output logic retry_o
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] C_FIRE_VAL = TIMER_W'(TIMEOUT_CYCLES - 2);

  logic               r_outstanding;
  logic [TIMER_W-1:0] r_timer;
  logic               r_retry;

  logic w_set;
  logic w_clear;
  logic w_active;
  logic w_fire_evt;

  // The request cycle itself counts as timer value 0, so the timer register
  // already holds k in the k-th cycle after the request. Firing one cycle
  // early (at TIMEOUT_CYCLES-2) and registering the pulse places the retry
  // exactly TIMEOUT_CYCLES-1 cycles after the request.
  assign w_set      = fetch_req_valid_i & ~icache_resp_valid_i;
  assign w_clear    = icache_resp_valid_i | flush_req_i | r_retry;
  assign w_active   = (r_outstanding | w_set) & ~w_clear;
  assign w_fire_evt = w_active & (r_timer == C_FIRE_VAL);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_outstanding <= 1'b0;
      r_timer       <= '0;
      r_retry       <= 1'b0;
    end else begin
      r_retry <= w_fire_evt;
      if (w_active && !w_fire_evt) begin
        r_outstanding <= 1'b1;
        r_timer       <= r_timer + TIMER_W'(1);
      end else begin
        r_outstanding <= 1'b0;
        r_timer       <= '0;
      end
    end
  end

  assign outstanding_o = r_outstanding;
  assign fire_evt_o    = w_fire_evt;
  assign retry_o       = r_retry;

endmodule : fetch_watchdog
`default_nettype wire

// File: rtl/fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq_ctrl
// Description : Fetch-stage sequencer. Runs the fence.i sequence (drain the
//               in-flight fetch, invalidate the icache, redirect fetch to the
//               resume PC) and watchdogs outstanding icache requests.
// Ports       : clk_i, rstn_i            clock / async active-low reset
//               fetch_req_valid_i        icache request issued
//               icache_resp_valid_i      icache response valid
//               flush_req_i              pipeline redirect
//               fence_i_req_i            fence.i pulse from commit
//               fence_resume_pc_i        PC to refetch after the fence
//               icache_inval_done_i      icache invalidation finished
//               fetch_stall_o            hold fetch
//               invalidate_icache_o      request icache invalidation
//               invalidate_buffer_o      drop the fetch line buffer
//               retry_fetch_o            retry the outstanding request
//               pc_jump_valid_o          select the jump PC
//               pc_jump_o                jump target
//               fence_done_o             fence.i sequence complete
//               busy_o                   sequencer not idle
//               retry_count_o            saturating retry count
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq_ctrl
  import drac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RETRY_CNT_W    = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   fetch_req_valid_i,
  input  logic                   icache_resp_valid_i,
  input  logic                   flush_req_i,
  input  logic                   fence_i_req_i,
  input  addrPC_t                fence_resume_pc_i,
  input  logic                   icache_inval_done_i,
  output logic                   fetch_stall_o,
  output logic                   invalidate_icache_o,
  output logic                   invalidate_buffer_o,
  output logic                   retry_fetch_o,
  output logic                   pc_jump_valid_o,
  output addrPC_t                pc_jump_o,
  output logic                   fence_done_o,
  output logic                   busy_o,
  output logic [RETRY_CNT_W-1:0] retry_count_o
);

  localparam logic [1:0] C_ST_IDLE   = FS_IDLE;
  localparam logic [1:0] C_ST_DRAIN  = FS_DRAIN;
  localparam logic [1:0] C_ST_INVAL  = FS_INVAL;
  localparam logic [1:0] C_ST_RESUME = FS_RESUME;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  addrPC_t                r_resume_pc;
  logic [RETRY_CNT_W-1:0] r_retry_cnt;

  logic w_outstanding;
  logic w_fire_evt;
  logic w_retry;

  fetch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .fetch_req_valid_i   (fetch_req_valid_i),
    .icache_resp_valid_i (icache_resp_valid_i),
    .flush_req_i         (flush_req_i),
    .outstanding_o       (w_outstanding),
    .fire_evt_o          (w_fire_evt),
    .retry_o             (w_retry)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE: begin
        // A same-cycle flush kills the request, so there is nothing to drain.
        if (fence_i_req_i) begin
          if (!w_outstanding || icache_resp_valid_i || flush_req_i)
            w_state_nxt = C_ST_INVAL;
          else
            w_state_nxt = C_ST_DRAIN;
        end
      end
      C_ST_DRAIN: begin
        // Besides response and timeout, a request dropped by a flush leaves
        // nothing in flight; without this exit DRAIN could never be left.
        if (icache_resp_valid_i || w_retry || !w_outstanding)
          w_state_nxt = C_ST_INVAL;
      end
      C_ST_INVAL: begin
        if (icache_inval_done_i)
          w_state_nxt = C_ST_RESUME;
      end
      default: begin
        w_state_nxt = C_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= C_ST_IDLE;
      r_resume_pc <= '0;
      r_retry_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == C_ST_IDLE && fence_i_req_i)
        r_resume_pc <= fence_resume_pc_i;
      if (w_fire_evt && !(&r_retry_cnt))
        r_retry_cnt <= r_retry_cnt + RETRY_CNT_W'(1);
    end
  end

  // All outputs are decoded from registers only.
  assign fetch_stall_o       = (r_state == C_ST_DRAIN) || (r_state == C_ST_INVAL);
  assign invalidate_icache_o = (r_state == C_ST_INVAL);
  assign invalidate_buffer_o = (r_state == C_ST_INVAL) || w_retry;
  assign retry_fetch_o       = w_retry;
  assign pc_jump_valid_o     = (r_state == C_ST_RESUME);
  assign pc_jump_o           = r_resume_pc;
  assign fence_done_o        = (r_state == C_ST_RESUME);
  assign busy_o              = (r_state != C_ST_IDLE);
  assign retry_count_o       = r_retry_cnt;

endmodule : fetch_seq_ctrl
`default_nettype wire

// File: tb/tb_fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_seq_ctrl
// Description : Directed self-checking bench for fetch_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_seq_ctrl;
  import drac_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        fetch_req_valid_i;
  logic        icache_resp_valid_i;
  logic        flush_req_i;
  logic        fence_i_req_i;
  addrPC_t     fence_resume_pc_i;
  logic        icache_inval_done_i;
  logic        fetch_stall_o;
  logic        invalidate_icache_o;
  logic        invalidate_buffer_o;
  logic        retry_fetch_o;
  logic        pc_jump_valid_o;
  addrPC_t     pc_jump_o;
  logic        fence_done_o;
  logic        busy_o;
  logic [7:0]  retry_count_o;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk_i = ~clk_i;

  fetch_seq_ctrl #(
    .TIMEOUT_CYCLES (64),
    .RETRY_CNT_W    (8)
  ) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .fetch_req_valid_i   (fetch_req_valid_i),
    .icache_resp_valid_i (icache_resp_valid_i),
    .flush_req_i         (flush_req_i),
    .fence_i_req_i       (fence_i_req_i),
    .fence_resume_pc_i   (fence_resume_pc_i),
    .icache_inval_done_i (icache_inval_done_i),
    .fetch_stall_o       (fetch_stall_o),
    .invalidate_icache_o (invalidate_icache_o),
    .invalidate_buffer_o (invalidate_buffer_o),
    .retry_fetch_o       (retry_fetch_o),
    .pc_jump_valid_o     (pc_jump_valid_o),
    .pc_jump_o           (pc_jump_o),
    .fence_done_o        (fence_done_o),
    .busy_o              (busy_o),
    .retry_count_o       (retry_count_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"},  64'(fetch_stall_o),       64'd0);
    check({tag, ".inval"},  64'(invalidate_icache_o), 64'd0);
    check({tag, ".buf"},    64'(invalidate_buffer_o), 64'd0);
    check({tag, ".retry"},  64'(retry_fetch_o),       64'd0);
    check({tag, ".jv"},     64'(pc_jump_valid_o),     64'd0);
    check({tag, ".pc"},     pc_jump_o,                64'd0);
    check({tag, ".done"},   64'(fence_done_o),        64'd0);
    check({tag, ".busy"},   64'(busy_o),              64'd0);
    check({tag, ".cnt"},    64'(retry_count_o),       64'd0);
  endtask

  initial begin
    logic saw;
    rstn_i              = 1'b0;
    fetch_req_valid_i   = 1'b0;
    icache_resp_valid_i = 1'b0;
    flush_req_i         = 1'b0;
    fence_i_req_i       = 1'b0;
    fence_resume_pc_i   = '0;
    icache_inval_done_i = 1'b1;

    // Reset state
    step(); step();
    check_all_zero("reset");
    rstn_i = 1'b1;
    step();

    // 1: fence with idle fetch, done tied high
    fence_i_req_i     = 1'b1;
    fence_resume_pc_i = 64'h8000_0100;
    check("t1.T0.busy", 64'(busy_o), 64'd0);
    step();
    fence_i_req_i = 1'b0;
    check("t1.T1.inval", 64'(invalidate_icache_o), 64'd1);
    check("t1.T1.stall", 64'(fetch_stall_o),       64'd1);
    check("t1.T1.buf",   64'(invalidate_buffer_o), 64'd1);
    check("t1.T1.done",  64'(fence_done_o),        64'd0);
    step();
    check("t1.T2.jv",    64'(pc_jump_valid_o), 64'd1);
    check("t1.T2.pc",    pc_jump_o,            64'h8000_0100);
    check("t1.T2.done",  64'(fence_done_o),    64'd1);
    check("t1.T2.stall", 64'(fetch_stall_o),   64'd0);
    step();
    check("t1.T3.busy", 64'(busy_o),          64'd0);
    check("t1.T3.done", 64'(fence_done_o),    64'd0);
    check("t1.T3.jv",   64'(pc_jump_valid_o), 64'd0);
    check("t1.T3.pc",   pc_jump_o,            64'h8000_0100);

    // 2: fence with a request outstanding, response 5 cycles after the fence
    fetch_req_valid_i = 1'b1;
    step();
    fetch_req_valid_i = 1'b0;
    fence_i_req_i     = 1'b1;
    fence_resume_pc_i = 64'h8000_0200;
    step();
    fence_i_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2.drain.stall", 64'(fetch_stall_o),       64'd1);
      check("t2.drain.inval", 64'(invalidate_icache_o), 64'd0);
      step();
    end
    check("t2.resp.stall", 64'(fetch_stall_o),       64'd1);
    check("t2.resp.inval", 64'(invalidate_icache_o), 64'd0);
    icache_resp_valid_i = 1'b1;
    step();
    icache_resp_valid_i = 1'b0;
    check("t2.inval", 64'(invalidate_icache_o), 64'd1);
    step();
    check("t2.done", 64'(fence_done_o), 64'd1);
    check("t2.pc",   pc_jump_o,         64'h8000_0200);
    step();
    check("t2.idle", 64'(busy_o), 64'd0);

    // 3: timeout; retry exactly at T0+63, then saturation after 300 retries
    fetch_req_valid_i = 1'b1;
    step();
    fetch_req_valid_i = 1'b0;
    saw = 1'b0;
    for (int i = 1; i < 63; i++) begin
      if (retry_fetch_o !== 1'b0) saw = 1'b1;
      step();
    end
    check("t3.early_retry", 64'(saw),                 64'd0);
    check("t3.retry",       64'(retry_fetch_o),       64'd1);
    check("t3.buf",         64'(invalidate_buffer_o), 64'd1);
    check("t3.cnt1",        64'(retry_count_o),       64'd1);
    step();
    check("t3.retry_off", 64'(retry_fetch_o), 64'd0);
    for (int n = 1; n < 300; n++) begin
      fetch_req_valid_i = 1'b1;
      step();
      fetch_req_valid_i = 1'b0;
      repeat (62) step();
      check("t3.rep_retry", 64'(retry_fetch_o), 64'd1);
      step();
    end
    check("t3.sat", 64'(retry_count_o), 64'd255);

    // 4: slow invalidation, done low for 10 INVAL cycles
    icache_inval_done_i = 1'b0;
    fence_i_req_i       = 1'b1;
    fence_resume_pc_i   = 64'h8000_0300;
    step();
    fence_i_req_i = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (invalidate_icache_o !== 1'b1 || fence_done_o !== 1'b0) saw = 1'b1;
      step();
    end
    check("t4.hold", 64'(saw), 64'd0);
    icache_inval_done_i = 1'b1;
    check("t4.last_inval", 64'(invalidate_icache_o), 64'd1);
    step();
    check("t4.done", 64'(fence_done_o), 64'd1);
    check("t4.pc",   pc_jump_o,         64'h8000_0300);
    step();

    // 5: flush and fence in the same IDLE cycle with a request outstanding
    fetch_req_valid_i = 1'b1;
    step();
    fetch_req_valid_i = 1'b0;
    flush_req_i       = 1'b1;
    fence_i_req_i     = 1'b1;
    fence_resume_pc_i = 64'h8000_0400;
    step();
    flush_req_i   = 1'b0;
    fence_i_req_i = 1'b0;
    check("t5.inval", 64'(invalidate_icache_o), 64'd1);
    step();
    check("t5.done", 64'(fence_done_o), 64'd1);
    check("t5.pc",   pc_jump_o,         64'h8000_0400);
    saw = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (retry_fetch_o !== 1'b0) saw = 1'b1;
      step();
    end
    check("t5.no_retry", 64'(saw), 64'd0);

    // 6: reset asserted while in INVAL
    icache_inval_done_i = 1'b0;
    fence_i_req_i       = 1'b1;
    fence_resume_pc_i   = 64'h8000_0500;
    step();
    fence_i_req_i = 1'b0;
    step();
    check("t6.pre_inval", 64'(invalidate_icache_o), 64'd1);
    rstn_i = 1'b0;
    #1;
    check_all_zero("t6.rst");
    step(); step();
    rstn_i              = 1'b1;
    icache_inval_done_i = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fence_done_o !== 1'b0 || busy_o !== 1'b0) saw = 1'b1;
    end
    check("t6.no_done", 64'(saw), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_fetch_seq_ctrl
`default_nettype wire
